// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation at a time; 32 CALC cycles for a normal op, direct to DONE for
// divide-by-zero and signed overflow. Drives the stall/overlap pair used by
// the hazard unit and returns the result on a one-cycle valid pulse.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    input  logic        kill,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        result_valid,
    output logic        div_stall,
    output logic        div_overlap,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement negation when n is set, pass-through otherwise.
    function automatic logic [31:0] negate_if(input logic [31:0] v, input logic n);
        negate_if = n ? (~v + 32'd1) : v;
    endfunction

    state_t      state_q, state_d;
    logic        op_rem_q, op_rem_d;      // 1: return remainder, 0: quotient
    logic        neg_quo_q, neg_quo_d;    // operand signs differed (signed op)
    logic        neg_rem_q, neg_rem_d;    // dividend was negative (signed op)
    logic [31:0] quo_q, quo_d;            // dividend shifting out / quotient shifting in
    logic [31:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_q, rd_d;

    // Operand preparation at issue: signs, magnitudes and special cases.
    logic        signed_op_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic        div_zero_s;
    logic        overflow_s;
    logic [31:0] special_res_s;

    assign signed_op_s = ~op[0];
    assign a_neg_s     = signed_op_s & op_a[31];
    assign b_neg_s     = signed_op_s & op_b[31];
    assign a_mag_s     = negate_if(op_a, a_neg_s);
    assign b_mag_s     = negate_if(op_b, b_neg_s);
    assign div_zero_s  = (op_b == 32'd0);
    assign overflow_s  = signed_op_s & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);

    // Divide by zero: quotient all ones, remainder is the dividend.
    // Signed overflow: quotient 0x80000000, remainder zero.
    assign special_res_s = op[1] ? (div_zero_s ? op_a : 32'd0)
                                 : (div_zero_s ? 32'hFFFF_FFFF : 32'h8000_0000);

    // One restoring step: shift {rem, quo}, subtract divisor at 33 bits.
    logic [32:0] rem_sh_s;
    logic [31:0] quo_sh_s;
    logic        trial_ge_s;
    logic [31:0] trial_s;
    logic [31:0] rem_nx_s;
    logic [31:0] quo_nx_s;
    logic [31:0] final_res_s;

    assign rem_sh_s    = {rem_q, quo_q[31]};
    assign quo_sh_s    = {quo_q[30:0], 1'b0};
    assign trial_ge_s  = (rem_sh_s >= {1'b0, divisor_q});
    // When the trial is non-negative the difference is below the divisor and fits 32 bits.
    assign trial_s     = rem_sh_s[31:0] - divisor_q;
    assign rem_nx_s    = trial_ge_s ? trial_s : rem_sh_s[31:0];
    assign quo_nx_s    = trial_ge_s ? (quo_sh_s | 32'd1) : quo_sh_s;
    assign final_res_s = op_rem_q ? negate_if(rem_nx_s, neg_rem_q)
                                  : negate_if(quo_nx_s, neg_quo_q);

    // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        op_rem_d  = op_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        count_d   = count_q;
        result_d  = result_q;
        rd_d      = rd_q;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    op_rem_d  = op[1];
                    neg_quo_d = a_neg_s ^ b_neg_s;
                    neg_rem_d = a_neg_s;
                    quo_d     = a_mag_s;
                    divisor_d = b_mag_s;
                    rem_d     = 32'd0;
                    count_d   = 5'd31;
                    rd_d      = rd_in;
                    if (div_zero_s || overflow_s) begin
                        result_d = special_res_s;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_nx_s;
                    quo_d = quo_nx_s;
                    if (count_q == 5'd0) begin
                        result_d = final_res_s;
                        state_d  = S_DONE;
                    end else begin
                        count_d = count_q - 5'd1;
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            divisor_q <= 32'd0;
            count_q   <= 5'd0;
            result_q  <= 32'd0;
            rd_q      <= 5'd0;
        end else begin
            state_q   <= state_d;
            op_rem_q  <= op_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            count_q   <= count_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
        end
    end

    assign result       = result_q;
    assign rd_out       = rd_q;
    assign result_valid = (state_q == S_DONE);
    assign div_overlap  = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    // Stall rises combinationally in the issue cycle so ID holds from T.
    assign div_stall    = ((state_q == S_IDLE) && start && !kill)
                        || (state_q == S_CALC) || (state_q == S_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        kill = 1'b0;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        result_valid;
    logic        div_stall;
    logic        div_overlap;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .rd_in(rd_in), .kill(kill), .result(result), .rd_out(rd_out),
        .result_valid(result_valid), .div_stall(div_stall),
        .div_overlap(div_overlap), .busy(busy)
    );

    always #5 clk = ~clk;

    // Present a start in the next cycle (inputs change at the falling edge).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b; rd_in = r;
    endtask

    // Step cycles after an issue until result_valid; reports latency and observations.
    task automatic wait_result(input int max_cyc, output int lat, output logic [31:0] res,
                               output logic [4:0] rdo, output int stall_lo, output int ovl_bad);
        lat = -1; res = 32'd0; rdo = 5'd0; stall_lo = 0; ovl_bad = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            if (!div_stall) stall_lo++;
            if (result_valid) begin
                lat = k; res = result; rdo = rd_out;
                if (!div_overlap) ovl_bad++;
                break;
            end else if (div_overlap) begin
                ovl_bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (result !== 32'd0) begin tests_failed++; $display("FAIL reset_result got %h exp 0", result); end
        tests_run++; if (rd_out !== 5'd0) begin tests_failed++; $display("FAIL reset_rd got %0d exp 0", rd_out); end
        tests_run++; if ({result_valid, div_stall, div_overlap, busy} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_flags got %b exp 0000", {result_valid, div_stall, div_overlap, busy}); end
        // rst overrides a start presented in the same cycle
        start = 1'b1; op = 2'b01; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0 || result_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_override busy=%b valid=%b exp 0 0", busy, result_valid); end
    endtask

    task automatic test_divu_basic();
        int lat, sl, ob; logic [31:0] r; logic [4:0] d;
        issue(2'b01, 32'd100, 32'd7, 5'd5);
        #1;
        tests_run++; if (div_stall !== 1'b1) begin tests_failed++; $display("FAIL issue_stall got %b exp 1", div_stall); end
        wait_result(40, lat, r, d, sl, ob);
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL divu_latency got %0d exp 33", lat); end
        tests_run++; if (r !== 32'd14) begin tests_failed++; $display("FAIL divu_result got %0d exp 14", r); end
        tests_run++; if (d !== 5'd5) begin tests_failed++; $display("FAIL divu_rd got %0d exp 5", d); end
        tests_run++; if (sl !== 0) begin tests_failed++; $display("FAIL divu_stall_gap got %0d low cycles exp 0", sl); end
        tests_run++; if (ob !== 0) begin tests_failed++; $display("FAIL divu_overlap got %0d bad cycles exp 0", ob); end
        @(negedge clk);
        tests_run++; if ({busy, div_stall, result_valid, div_overlap} !== 4'b0000) begin
            tests_failed++; $display("FAIL divu_back_idle got %b exp 0000", {busy, div_stall, result_valid, div_overlap}); end
    endtask

    task automatic test_vectors();
        logic [1:0]  v_op  [16];
        logic [31:0] v_a   [16];
        logic [31:0] v_b   [16];
        logic [31:0] v_exp [16];
        int          v_lat [16];
        int lat, sl, ob; logic [31:0] r; logic [4:0] d;
        v_op[0]  = 2'b10; v_a[0]  = 32'hFFFF_FFF9; v_b[0]  = 32'd2;          v_exp[0]  = 32'hFFFF_FFFF; v_lat[0]  = 33;
        v_op[1]  = 2'b00; v_a[1]  = 32'hFFFF_FFF9; v_b[1]  = 32'd2;          v_exp[1]  = 32'hFFFF_FFFD; v_lat[1]  = 33;
        v_op[2]  = 2'b11; v_a[2]  = 32'hFFFF_FFF9; v_b[2]  = 32'd2;          v_exp[2]  = 32'd1;         v_lat[2]  = 33;
        v_op[3]  = 2'b00; v_a[3]  = 32'd123;       v_b[3]  = 32'd0;          v_exp[3]  = 32'hFFFF_FFFF; v_lat[3]  = 1;
        v_op[4]  = 2'b11; v_a[4]  = 32'd123;       v_b[4]  = 32'd0;          v_exp[4]  = 32'd123;       v_lat[4]  = 1;
        v_op[5]  = 2'b00; v_a[5]  = 32'h8000_0000; v_b[5]  = 32'hFFFF_FFFF; v_exp[5]  = 32'h8000_0000; v_lat[5]  = 1;
        v_op[6]  = 2'b10; v_a[6]  = 32'h8000_0000; v_b[6]  = 32'hFFFF_FFFF; v_exp[6]  = 32'd0;         v_lat[6]  = 1;
        v_op[7]  = 2'b01; v_a[7]  = 32'd123;       v_b[7]  = 32'd0;          v_exp[7]  = 32'hFFFF_FFFF; v_lat[7]  = 1;
        v_op[8]  = 2'b10; v_a[8]  = 32'h8000_0000; v_b[8]  = 32'd0;          v_exp[8]  = 32'h8000_0000; v_lat[8]  = 1;
        v_op[9]  = 2'b01; v_a[9]  = 32'h8000_0000; v_b[9]  = 32'hFFFF_FFFF; v_exp[9]  = 32'd0;         v_lat[9]  = 33;
        v_op[10] = 2'b11; v_a[10] = 32'h8000_0000; v_b[10] = 32'hFFFF_FFFF; v_exp[10] = 32'h8000_0000; v_lat[10] = 33;
        v_op[11] = 2'b00; v_a[11] = 32'hFFFF_FF9C; v_b[11] = 32'd7;          v_exp[11] = 32'hFFFF_FFF2; v_lat[11] = 33;
        v_op[12] = 2'b10; v_a[12] = 32'hFFFF_FF9C; v_b[12] = 32'd7;          v_exp[12] = 32'hFFFF_FFFE; v_lat[12] = 33;
        v_op[13] = 2'b00; v_a[13] = 32'd7;         v_b[13] = 32'hFFFF_FFFD; v_exp[13] = 32'hFFFF_FFFE; v_lat[13] = 33;
        v_op[14] = 2'b10; v_a[14] = 32'd7;         v_b[14] = 32'hFFFF_FFFD; v_exp[14] = 32'd1;         v_lat[14] = 33;
        v_op[15] = 2'b11; v_a[15] = 32'hFFFF_FFFE; v_b[15] = 32'hFFFF_FFFF; v_exp[15] = 32'hFFFF_FFFE; v_lat[15] = 33;
        for (int i = 0; i < 16; i++) begin
            issue(v_op[i], v_a[i], v_b[i], 5'(i + 1));
            wait_result(40, lat, r, d, sl, ob);
            tests_run++; if (r !== v_exp[i] || lat !== v_lat[i] || d !== 5'(i + 1)) begin
                tests_failed++;
                $display("FAIL vec%0d got res=%h lat=%0d rd=%0d exp res=%h lat=%0d rd=%0d",
                         i, r, lat, d, v_exp[i], v_lat[i], i + 1);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_kill();
        int lat, sl, ob; logic [31:0] r; logic [4:0] d;
        issue(2'b01, 32'd1000, 32'd3, 5'd7);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
        end
        kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0 || div_stall !== 1'b0 || result_valid !== 1'b0) begin
            tests_failed++; $display("FAIL kill_idle busy=%b stall=%b valid=%b exp 0 0 0", busy, div_stall, result_valid); end
        start = 1'b1; op = 2'b01; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd8;
        #1;
        tests_run++; if (div_stall !== 1'b1) begin tests_failed++; $display("FAIL kill_restart_stall got %b exp 1", div_stall); end
        wait_result(40, lat, r, d, sl, ob);
        tests_run++; if (lat !== 33 || r !== 32'd3 || d !== 5'd8) begin
            tests_failed++; $display("FAIL kill_restart got lat=%0d res=%0d rd=%0d exp 33 3 8", lat, r, d); end
        @(negedge clk);
    endtask

    task automatic test_start_in_calc();
        int vbad = 0;
        issue(2'b01, 32'd100, 32'd7, 5'd5);
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            start = (k == 5);
            if (k == 5) begin op = 2'b00; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd9; end
            @(negedge clk);
            if (k < 33 && result_valid) vbad++;
        end
        tests_run++; if (result_valid !== 1'b1 || result !== 32'd14 || rd_out !== 5'd5 || vbad !== 0) begin
            tests_failed++; $display("FAIL start_in_calc got valid=%b res=%0d rd=%0d early=%0d exp 1 14 5 0",
                                     result_valid, result, rd_out, vbad); end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int vcnt = 0;
        issue(2'b01, 32'd100, 32'd7, 5'd5);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        tests_run++; if ({result, rd_out} !== 37'd0) begin
            tests_failed++; $display("FAIL rst_mid_data got res=%h rd=%0d exp 0 0", result, rd_out); end
        tests_run++; if ({result_valid, div_stall, div_overlap, busy} !== 4'b0000) begin
            tests_failed++; $display("FAIL rst_mid_flags got %b exp 0000", {result_valid, div_stall, div_overlap, busy}); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (result_valid) vcnt++;
        end
        tests_run++; if (vcnt !== 0) begin tests_failed++; $display("FAIL rst_mid_no_valid got %0d pulses exp 0", vcnt); end
    endtask

    task automatic test_back_to_back();
        int sl = 0; int extra = 0;
        logic [31:0] r1 = 32'd0; logic [31:0] r2 = 32'd0;
        logic [4:0] d1 = 5'd0; logic [4:0] d2 = 5'd0;
        logic v1 = 1'b0; logic v2 = 1'b0;
        issue(2'b01, 32'd10, 32'd3, 5'd1);
        #1 if (!div_stall) sl++;
        for (int k = 1; k <= 67; k++) begin
            @(posedge clk); #1;
            if (k == 34) begin start = 1'b1; op = 2'b11; op_a = 32'd10; op_b = 32'd3; rd_in = 5'd2; end
            else start = 1'b0;
            @(negedge clk);
            if (!div_stall) sl++;
            if (result_valid) begin
                if (k == 33) begin v1 = 1'b1; r1 = result; d1 = rd_out; end
                else if (k == 67) begin v2 = 1'b1; r2 = result; d2 = rd_out; end
                else extra++;
            end
        end
        tests_run++; if (v1 !== 1'b1 || r1 !== 32'd3 || d1 !== 5'd1) begin
            tests_failed++; $display("FAIL b2b_first got valid=%b res=%0d rd=%0d exp 1 3 1", v1, r1, d1); end
        tests_run++; if (v2 !== 1'b1 || r2 !== 32'd1 || d2 !== 5'd2) begin
            tests_failed++; $display("FAIL b2b_second got valid=%b res=%0d rd=%0d exp 1 1 2", v2, r2, d2); end
        tests_run++; if (sl !== 0 || extra !== 0) begin
            tests_failed++; $display("FAIL b2b_stall got low=%0d extra=%0d exp 0 0", sl, extra); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_vectors();
        test_kill();
        test_start_in_calc();
        test_rst_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
